// File: rtl/div_defs.sv
// rtl/div_defs.sv - shared state encodings and constants for the sequential divider
package div_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SP_NONE = 2'd0,
      SP_DIV0 = 2'd1,
      SP_OVF  = 2'd2
   } special_t;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// rtl/div_seq_ctrl_if.sv - request/result bundle between the datapath and the divider
interface div_seq_ctrl_if #(parameter int WIDTH = 32);

   logic             start;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] T;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Y_Hi;
   logic [WIDTH-1:0] Y_Lo;
   logic             V;
   logic             C;
   logic             Z;

   modport master (
      output start, S, T,
      input  busy, done, Y_Hi, Y_Lo, V, C, Z
   );

   modport slave (
      input  start, S, T,
      output busy, done, Y_Hi, Y_Lo, V, C, Z
   );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract step on unsigned magnitudes
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;

   // Shifted remainder keeps its carry bit so the compare is exact.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      if (shifted >= {1'b0, divisor}) begin
         rem_next = shifted[WIDTH-1:0] - divisor;
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle signed divider: quotient on Y_Lo, remainder on Y_Hi
module div_seq_ctrl
   import div_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic         clk,
   input  logic         reset,
   div_seq_ctrl_if.slave bus
);

   state_t           state;
   state_t           state_next;
   special_t         spc;
   special_t         spc_in;
   logic             req;
   logic [WIDTH-1:0] s_reg;
   logic [WIDTH-1:0] t_reg;
   logic [WIDTH-1:0] mag_s;
   logic [WIDTH-1:0] mag_t;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [CNT_W-1:0] cnt;
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH-1:0] fix_lo;
   logic [WIDTH-1:0] fix_hi;
   logic             fix_v;
   logic [WIDTH-1:0] y_lo;
   logic [WIDTH-1:0] y_hi;
   logic             v_reg;
   logic             z_reg;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (divisor),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_comb begin
      mag_s  = s_reg[WIDTH-1] ? -s_reg : s_reg;
      mag_t  = t_reg[WIDTH-1] ? -t_reg : t_reg;
      spc_in = SP_NONE;
      if (t_reg == '0)
         spc_in = SP_DIV0;
      else if (s_reg == WIDTH'(INT_MIN) && t_reg == WIDTH'(NEG_ONE))
         spc_in = SP_OVF;
   end

   always_comb begin
      fix_lo = sign_q ? -quo : quo;
      fix_hi = sign_r ? -rem : rem;
      fix_v  = 1'b0;
      case (spc)
         SP_DIV0: begin
            fix_lo = WIDTH'(NEG_ONE);
            fix_hi = s_reg;
            fix_v  = 1'b1;
         end
         SP_OVF: begin
            fix_lo = WIDTH'(INT_MIN);
            fix_hi = '0;
            fix_v  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req) state_next = (spc_in != SP_NONE) ? FIX : CALC;
         CALC:    if (cnt == CNT_W'(1)) state_next = FIX;
         FIX:     state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == CALC) || (state == FIX);
      bus.done = (state == DONE);
      bus.Y_Lo = y_lo;
      bus.Y_Hi = y_hi;
      bus.V    = v_reg;
      bus.C    = 1'b0;
      bus.Z    = z_reg;
   end

   // Operands are latched on the start edge and decoded on the following IDLE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req     <= 1'b0;
         s_reg   <= '0;
         t_reg   <= '0;
         divisor <= '0;
         rem     <= '0;
         quo     <= '0;
         cnt     <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         spc     <= SP_NONE;
         y_lo    <= '0;
         y_hi    <= '0;
         v_reg   <= 1'b0;
         z_reg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  req     <= 1'b0;
                  divisor <= mag_t;
                  quo     <= mag_s;
                  rem     <= '0;
                  sign_q  <= s_reg[WIDTH-1] ^ t_reg[WIDTH-1];
                  sign_r  <= s_reg[WIDTH-1];
                  spc     <= spc_in;
                  cnt     <= CNT_W'(WIDTH);
               end else if (bus.start) begin
                  s_reg <= bus.S;
                  t_reg <= bus.T;
                  req   <= 1'b1;
               end
            end
            CALC: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: begin
               y_lo  <= fix_lo;
               y_hi  <= fix_hi;
               v_reg <= fix_v;
               z_reg <= (fix_lo == '0);
            end
            default: ;
         endcase
      end
   end

endmodule
